// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory read per PC value, delivers the word to decode,
// and advances the PC only on decode acceptance. Bus errors and response timeouts latch a sticky fault.
module fetch_unit #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [1:0]         pc_handle,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [INSTR_W-1:0] mem_rsp_data,
  input  logic               mem_rsp_err,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [ADDR_W-1:0]  fault_pc
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;
  logic [1:0]         code_q, code_d;
  logic [ADDR_W-1:0]  fpc_q, fpc_d;

  // Valids are pure state decodes so they drop the instant reset asserts.
  assign mem_req_valid = (state_q == S_REQ);
  assign instr_valid   = (state_q == S_OUT);
  assign pc_handle     = {1'b0, instr_valid & instr_ready};
  assign mem_req_addr  = addr_q;
  assign instr_data    = data_q;
  assign instr_pc      = ipc_q;
  assign fault         = fault_q;
  assign fault_code    = code_q;
  assign fault_pc      = fpc_q;

  // Next-state and datapath update for the fetch sequence.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    code_d  = code_q;
    fpc_d   = fpc_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_en) begin
          addr_d  = pc_in;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        // A response arriving on the last allowed cycle still wins over the watchdog.
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            fault_d = 1'b1;
            code_d  = 2'b01;
            fpc_d   = addr_q;
            state_d = S_FAULT;
          end else begin
            data_d  = mem_rsp_data;
            ipc_d   = addr_q;
            state_d = S_OUT;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == TO_VAL)) begin
          fault_d = 1'b1;
          code_d  = 2'b10;
          fpc_d   = addr_q;
          state_d = S_FAULT;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_OUT: begin
        // pc_in still holds the delivered PC here; the PC itself steps on this same edge.
        if (instr_ready) begin
          if (fetch_en) begin
            addr_d  = pc_in + ADDR_W'(1);
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      fpc_q   <= fpc_d;
    end
  end

endmodule
